// File: rtl/ps2_key_if.sv
// Byte-stream / key-event bundle between the PS/2 receiver side and ps2_key_decoder.
// master drives bytes and observes key state; slave decodes bytes and drives key state.
interface ps2_key_if #(
   parameter int NUM_KEYS = 29,
   parameter int IDX_W    = 5
);
   logic [7:0]          recievedData;
   logic                recievedNewData;
   logic [NUM_KEYS-1:0] keyState;
   logic                keyEvent;
   logic [IDX_W-1:0]    keyIndex;
   logic                keyReleased;

   modport master (
      output recievedData, recievedNewData,
      input  keyState, keyEvent, keyIndex, keyReleased
   );

   modport slave (
      input  recievedData, recievedNewData,
      output keyState, keyEvent, keyIndex, keyReleased
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: held-key vector plus one-cycle press/release events for 29 keys.
// Build option PS2_REPEAT_FILTER_EN suppresses press events for typematic repeats of held keys.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix byte
// BREAK   | F0 seen; next byte names the key being released
// EXT     | E0 seen; extended make codes are ignored
// EXT_BRK | E0 F0 seen; the next byte (extended break) is ignored
module ps2_key_decoder #(
   parameter int NUM_KEYS = 29,
   parameter int IDX_W    = 5
) (
   input logic      CLOCK_50,
   input logic      reset,
   ps2_key_if.slave ps2
);
   typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BRK} state_t;

   localparam logic [7:0] CODE_BRK = 8'hF0;
   localparam logic [7:0] CODE_EXT = 8'hE0;

   state_t              state;
   logic                codeHit;
   logic [IDX_W-1:0]    codeIdx;
   logic [NUM_KEYS-1:0] keyMask;
   logic                isHeld;

   always_comb begin
      codeHit = 1'b1;
      codeIdx = '0;
      case (ps2.recievedData)
         8'h45: codeIdx = IDX_W'(0);
         8'h16: codeIdx = IDX_W'(1);
         8'h1E: codeIdx = IDX_W'(2);
         8'h26: codeIdx = IDX_W'(3);
         8'h25: codeIdx = IDX_W'(4);
         8'h2E: codeIdx = IDX_W'(5);
         8'h36: codeIdx = IDX_W'(6);
         8'h3D: codeIdx = IDX_W'(7);
         8'h3E: codeIdx = IDX_W'(8);
         8'h46: codeIdx = IDX_W'(9);
         8'h0E: codeIdx = IDX_W'(10);
         8'h4E: codeIdx = IDX_W'(11);
         8'h55: codeIdx = IDX_W'(12);
         8'h66: codeIdx = IDX_W'(13);
         8'h0D: codeIdx = IDX_W'(14);
         8'h15: codeIdx = IDX_W'(15);
         8'h1D: codeIdx = IDX_W'(16);
         8'h24: codeIdx = IDX_W'(17);
         8'h2D: codeIdx = IDX_W'(18);
         8'h2C: codeIdx = IDX_W'(19);
         8'h35: codeIdx = IDX_W'(20);
         8'h3C: codeIdx = IDX_W'(21);
         8'h43: codeIdx = IDX_W'(22);
         8'h44: codeIdx = IDX_W'(23);
         8'h4D: codeIdx = IDX_W'(24);
         8'h54: codeIdx = IDX_W'(25);
         8'h5B: codeIdx = IDX_W'(26);
         8'h5D: codeIdx = IDX_W'(27);
         8'h29: codeIdx = IDX_W'(28);
         default: codeHit = 1'b0;
      endcase
   end

   // One-hot mask keeps the held test and bit updates free of variable part-selects.
   always_comb begin
      keyMask = '0;
      if (codeHit) keyMask = NUM_KEYS'(1) << codeIdx;
      isHeld = |(ps2.keyState & keyMask);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         ps2.keyState    <= '0;
         ps2.keyEvent    <= 1'b0;
         ps2.keyIndex    <= '0;
         ps2.keyReleased <= 1'b0;
      end else begin
         ps2.keyEvent <= 1'b0;
         if (ps2.recievedNewData) begin
            case (state)
               IDLE: begin
                  if (ps2.recievedData == CODE_BRK) begin
                     state <= BREAK;
                  end else if (ps2.recievedData == CODE_EXT) begin
                     state <= EXT;
                  end else if (codeHit) begin
                     ps2.keyState <= ps2.keyState | keyMask;
`ifdef PS2_REPEAT_FILTER_EN
                     if (!isHeld) begin
                        ps2.keyEvent    <= 1'b1;
                        ps2.keyIndex    <= codeIdx;
                        ps2.keyReleased <= 1'b0;
                     end
`else
                     ps2.keyEvent    <= 1'b1;
                     ps2.keyIndex    <= codeIdx;
                     ps2.keyReleased <= 1'b0;
`endif
                  end
               end
               BREAK: begin
                  state <= IDLE;
                  // Releasing a key that is not held is silently dropped.
                  if (codeHit && isHeld) begin
                     ps2.keyState    <= ps2.keyState & ~keyMask;
                     ps2.keyEvent    <= 1'b1;
                     ps2.keyIndex    <= codeIdx;
                     ps2.keyReleased <= 1'b1;
                  end
               end
               EXT: begin
                  state <= (ps2.recievedData == CODE_BRK) ? EXT_BRK : IDLE;
               end
               EXT_BRK: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized self-checking bench for ps2_key_decoder against a prefix-queue reference model.
// Honours PS2_REPEAT_FILTER_EN the same way as the design build.
module tb_ps2_key_decoder;
   localparam int NUM_KEYS = 29;
   localparam int IDX_W    = 5;
   localparam logic [7:0] CODES [NUM_KEYS] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h0E, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
      8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};
   localparam logic [7:0] SPECIALS [5] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;
   always #10 CLOCK_50 = ~CLOCK_50;

   ps2_key_if #(.NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) bus ();

   ps2_key_decoder #(.NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .ps2      (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   bit         held [NUM_KEYS];
   logic [7:0] prefix [$];
   bit         expEv;
   int         expIdx;
   bit         expRel;
   int         evCount;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lookup(input logic [7:0] b);
      for (int i = 0; i < NUM_KEYS; i++)
         if (CODES[i] == b) return i;
      return -1;
   endfunction

   function automatic logic [31:0] heldVec();
      logic [31:0] v = '0;
      for (int i = 0; i < NUM_KEYS; i++) v[i] = held[i];
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NUM_KEYS; i++) held[i] = 1'b0;
      prefix.delete();
      expEv  = 1'b0;
      expIdx = 0;
      expRel = 1'b0;
   endtask

   task automatic modelByte(input logic [7:0] b);
      int idx;
      idx   = lookup(b);
      expEv = 1'b0;
      if (prefix.size() == 0) begin
         if (b == 8'hF0 || b == 8'hE0) begin
            prefix.push_back(b);
         end else if (idx >= 0) begin
`ifdef PS2_REPEAT_FILTER_EN
            expEv = !held[idx];
`else
            expEv = 1'b1;
`endif
            if (expEv) begin
               expIdx = idx;
               expRel = 1'b0;
            end
            held[idx] = 1'b1;
         end
      end else if (prefix.size() == 1 && prefix[0] == 8'hF0) begin
         prefix.delete();
         if (idx >= 0 && held[idx]) begin
            held[idx] = 1'b0;
            expEv  = 1'b1;
            expIdx = idx;
            expRel = 1'b1;
         end
      end else if (prefix.size() == 1 && prefix[0] == 8'hE0 && b == 8'hF0) begin
         prefix.push_back(b);
      end else begin
         prefix.delete();
      end
   endtask

   // One clock: optionally present a byte, then compare outputs after the edge.
   task automatic step(input bit valid, input logic [7:0] data);
      @(negedge CLOCK_50);
      bus.recievedNewData = valid;
      bus.recievedData    = valid ? data : 8'($urandom);
      @(posedge CLOCK_50);
      #1;
      if (valid) modelByte(data);
      else expEv = 1'b0;
      if (bus.keyEvent) evCount++;
      chk("keyEvent", 32'(bus.keyEvent), 32'(expEv));
      chk("keyIndex", 32'(bus.keyIndex), 32'(expIdx));
      if (expEv) chk("keyReleased", 32'(bus.keyReleased), 32'(expRel));
      chk("keyState", 32'(bus.keyState), heldVec());
   endtask

   task automatic midReset();
      @(negedge CLOCK_50);
      bus.recievedNewData = 1'b0;
      #3 reset = 1'b1;
      #1;
      modelReset();
      chk("rst_keyState", 32'(bus.keyState), 32'd0);
      chk("rst_keyEvent", 32'(bus.keyEvent), 32'd0);
      chk("rst_keyIndex", 32'(bus.keyIndex), 32'd0);
      chk("rst_keyReleased", 32'(bus.keyReleased), 32'd0);
      @(negedge CLOCK_50);
      reset = 1'b0;
   endtask

   initial begin
      int sel;
      logic [7:0] b;
      bus.recievedNewData = 1'b0;
      bus.recievedData    = 8'h00;
      modelReset();
      evCount = 0;
      #25;
      chk("por_keyState", 32'(bus.keyState), 32'd0);
      chk("por_keyEvent", 32'(bus.keyEvent), 32'd0);
      @(negedge CLOCK_50);
      reset = 1'b0;

      // press / release of one key, back-to-back bytes
      step(1, 8'h15); step(1, 8'hF0); step(1, 8'h15); step(0, 8'h00);
      // independent keys
      step(1, 8'h15); step(1, 8'h1D); step(0, 8'h00); step(1, 8'hF0); step(1, 8'h15);
      step(1, 8'hF0); step(1, 8'h1D);
      // typematic repeat
      evCount = 0;
      step(1, 8'h15); step(1, 8'h15); step(1, 8'h15); step(0, 8'h00);
`ifdef PS2_REPEAT_FILTER_EN
      chk("repeat_events", 32'(evCount), 32'd1);
`else
      chk("repeat_events", 32'(evCount), 32'd3);
`endif
      // extended sequences ignored, then key 28
      step(1, 8'hE0); step(1, 8'h75); step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75);
      step(1, 8'h29); step(0, 8'h00);
      // release of non-held key and special bytes in IDLE
      step(1, 8'hF0); step(1, 8'h1E); step(1, 8'hAA); step(1, 8'hFA);
      step(1, 8'h45); step(0, 8'h00);
      // malformed break prefix
      step(1, 8'hF0); step(1, 8'hE0); step(1, 8'h45);
      // reset mid-sequence, then break of an unheld key
      step(1, 8'h15); step(1, 8'hF0);
      midReset();
      step(1, 8'hF0); step(1, 8'h15); step(0, 8'h00);
      // pending prefix discarded by reset
      step(1, 8'hF0);
      midReset();
      step(1, 8'h15); step(0, 8'h00);

      for (int n = 0; n < 4000; n++) begin
         sel = $urandom_range(0, 11);
         if (sel <= 4)       b = CODES[$urandom_range(0, NUM_KEYS - 1)];
         else if (sel <= 6)  b = 8'hF0;
         else if (sel == 7)  b = 8'hE0;
         else if (sel == 8)  b = SPECIALS[$urandom_range(0, 4)];
         else                b = 8'($urandom);
         if (sel == 11) step(0, 8'h00);
         else step(1, b);
         if (n % 997 == 500) midReset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
